// File: rtl/ifid_skid_reg_if.sv
// IF/ID handshake bundle: fetch side, decode side, flush and bubble count.
// master = fetch/decode environment, slave = the pipeline register.
interface ifid_skid_reg_if #(
    parameter int PC_W    = 4,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    in_next_pc;
    logic [INSTR_W-1:0] in_instr;
    logic [INSTR_W-1:0] in_next_instr;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_next_pc;
    logic [INSTR_W-1:0] out_instr;
    logic [INSTR_W-1:0] out_next_instr;
    logic               flush;
    logic [CNT_W-1:0]   bubble_cnt;

    modport master (
        output in_valid,
        output in_next_pc,
        output in_instr,
        output in_next_instr,
        output out_ready,
        output flush,
        input  in_ready,
        input  out_valid,
        input  out_next_pc,
        input  out_instr,
        input  out_next_instr,
        input  bubble_cnt
    );

    modport slave (
        input  in_valid,
        input  in_next_pc,
        input  in_instr,
        input  in_next_instr,
        input  out_ready,
        input  flush,
        output in_ready,
        output out_valid,
        output out_next_pc,
        output out_instr,
        output out_next_instr,
        output bubble_cnt
    );
endinterface

// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register with one-entry skid buffer, flush-to-bubble
// and a saturating decode-starvation counter.
module ifid_skid_reg #(
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_W      = 4,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000,
    parameter int                 CNT_W     = 16
) (
    input  logic           clk,
    input  logic           rst,
    ifid_skid_reg_if.slave bus
);
    localparam int PW = PC_W + 2 * INSTR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PW-1:0]    r_main;
    logic [PW-1:0]    r_skid;
    logic [CNT_W-1:0] r_cnt;

    logic          w_main_valid;
    logic          w_skid_valid;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_consume;
    logic          w_ld_main_in;
    logic          w_ld_main_skid;
    logic          w_ld_skid;
    logic [PW-1:0] w_in_pay;

    // Readiness depends only on flops and rst, never on out_ready.
    assign w_main_valid = (r_state != S_EMPTY);
    assign w_skid_valid = (r_state == S_FULL);
    assign w_in_ready   = ~w_skid_valid & ~rst;
    assign w_accept     = bus.in_valid & w_in_ready;
    assign w_consume    = w_main_valid & bus.out_ready;
    assign w_in_pay     = {bus.in_next_pc, bus.in_instr, bus.in_next_instr};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: flush drops everything, otherwise FIFO occupancy update.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            unique case (r_state)
                S_EMPTY: begin
                    if (w_accept) w_state_nxt = S_ONE;
                end
                S_ONE: begin
                    if (w_accept && !w_consume) w_state_nxt = S_FULL;
                    else if (!w_accept && w_consume) w_state_nxt = S_EMPTY;
                end
                S_FULL: begin
                    if (w_consume) w_state_nxt = S_ONE;
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // Payload load strobes for the main and skid entries.
    always_comb begin
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (!bus.flush) begin
            unique case (r_state)
                S_EMPTY: begin
                    w_ld_main_in = w_accept;
                end
                S_ONE: begin
                    w_ld_main_in = w_accept & w_consume;
                    w_ld_skid    = w_accept & ~w_consume;
                end
                S_FULL: begin
                    w_ld_main_skid = w_consume;
                end
                default: begin
                    w_ld_main_in = 1'b0;
                end
            endcase
        end
    end

    // Payload registers; main drives the decode side, skid absorbs a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_ld_main_in) begin
                r_main <= w_in_pay;
            end else if (w_ld_main_skid) begin
                r_main <= r_skid;
            end
            if (w_ld_skid) begin
                r_skid <= w_in_pay;
            end
        end
    end

    // Count cycles where decode was ready but had nothing; saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (bus.out_ready && !w_main_valid && r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    assign bus.in_ready       = w_in_ready;
    assign bus.out_valid      = w_main_valid;
    assign bus.out_next_pc    = r_main[PW-1 -: PC_W];
    assign bus.out_instr      = w_main_valid ?
                                r_main[2*INSTR_W-1 -: INSTR_W] : NOP_INSTR;
    assign bus.out_next_instr = r_main[INSTR_W-1:0];
    assign bus.bubble_cnt     = r_cnt;
endmodule

// File: tb/tb_ifid_skid_reg.sv
// Self-checking bench for ifid_skid_reg: directed plan steps, then
// random traffic, all checked against a queue-based FIFO model.
module tb_ifid_skid_reg;
    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam int CMAX = 3;

    typedef struct packed {
        logic [3:0]  pc;
        logic [31:0] ins;
        logic [31:0] nins;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   m_cnt = 0;
    bit   m_known = 0;
    ent_t q[$];

    ifid_skid_reg_if #(.PC_W(4), .INSTR_W(32), .CNT_W(2)) b ();

    ifid_skid_reg #(
        .INSTR_W(32),
        .PC_W(4),
        .NOP_INSTR(NOP),
        .CNT_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero();
        chk("rst_next_pc", {60'd0, b.out_next_pc}, 64'd0);
        chk("rst_next_instr", {32'd0, b.out_next_instr}, 64'd0);
    endtask

    task automatic step(input logic r, input logic iv, input logic [3:0] pc,
                        input logic [31:0] ins, input logic ordy,
                        input logic fl);
        ent_t e;
        bit   rdy;
        bit   acc;
        bit   con;
        @(negedge clk);
        rst             = r;
        b.in_valid      = iv;
        b.in_next_pc    = pc;
        b.in_instr      = ins;
        b.in_next_instr = ins ^ 32'hA5A5_0000;
        b.out_ready     = ordy;
        b.flush         = fl;
        #1;
        rdy = !r && (q.size() < 2);
        if (m_known) begin
            chk("in_ready", {63'd0, b.in_ready}, {63'd0, rdy});
            chk("out_valid", {63'd0, b.out_valid}, {63'd0, q.size() != 0});
            if (q.size() != 0) begin
                chk("out_instr", {32'd0, b.out_instr}, {32'd0, q[0].ins});
                chk("out_next_pc", {60'd0, b.out_next_pc}, {60'd0, q[0].pc});
                chk("out_next_instr", {32'd0, b.out_next_instr},
                    {32'd0, q[0].nins});
            end else begin
                chk("out_instr_nop", {32'd0, b.out_instr}, {32'd0, NOP});
            end
            chk("bubble_cnt", {62'd0, b.bubble_cnt}, 64'(m_cnt));
        end
        e.pc   = pc;
        e.ins  = ins;
        e.nins = ins ^ 32'hA5A5_0000;
        if (r) begin
            q.delete();
            m_cnt   = 0;
            m_known = 1;
        end else begin
            acc = iv && rdy;
            con = (q.size() != 0) && ordy;
            if (ordy && q.size() == 0 && m_cnt < CMAX) m_cnt++;
            if (fl) begin
                q.delete();
            end else begin
                if (con) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
        end
    endtask

    initial begin
        b.in_valid      = 1'b0;
        b.in_next_pc    = '0;
        b.in_instr      = '0;
        b.in_next_instr = '0;
        b.out_ready     = 1'b0;
        b.flush         = 1'b0;

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk_zero();

        step(0, 1, 1, 32'h11, 1, 0);
        step(0, 1, 2, 32'h22, 1, 0);
        step(0, 1, 3, 32'h33, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);

        step(0, 1, 1, 32'h11, 0, 0);
        step(0, 1, 2, 32'h22, 0, 0);
        step(0, 1, 3, 32'h66, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);

        step(0, 1, 1, 32'h11, 0, 0);
        step(0, 1, 2, 32'h22, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 1, 4, 32'h44, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);

        step(0, 1, 1, 32'h11, 0, 0);
        step(0, 1, 5, 32'h55, 0, 1);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);

        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);

        step(0, 1, 7, 32'h77, 0, 0);
        step(0, 1, 8, 32'h88, 0, 0);
        step(1, 1, 9, 32'h99, 1, 0);
        step(1, 1, 9, 32'h99, 1, 0);
        chk_zero();
        step(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 9) < 7),
                 4'($urandom),
                 $urandom,
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 11) == 0));
        end
        step(0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ifid_skid_reg.md
# ifid_skid_reg

Parametrised IF/ID pipeline register with a valid/ready handshake, a one-entry skid buffer, flush-to-bubble, and a saturating bubble counter. It sits between fetch and decode. It replaces the enable-only IF/ID latch so that decode back-pressure never has to be routed combinationally into fetch. Ordering is strictly FIFO, with at most two instructions in flight.

## Interface
- INSTR_W, 32, width of `instr` and `next_instr` payloads
- PC_W, 4, width of the next-PC payload
- NOP_INSTR, 32'h0000_0000, value driven on `out_instr` whenever `out_valid`=0 (width INSTR_W)
- CNT_W, 16, width of the bubble counter

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  block can accept this cycle
- in_next_pc  in  PC_W  next-PC of fetched instruction
- in_instr  in  INSTR_W  fetched instruction
- in_next_instr  in  INSTR_W  following instruction word
- out_valid  out  1  decode-side entry valid
- out_ready  in  1  decode consumes this cycle
- out_next_pc  out  PC_W  payload of head entry
- out_instr  out  INSTR_W  payload of head entry; NOP_INSTR when empty
- out_next_instr  out  INSTR_W  payload of head entry
- flush  in  1  discard all held and incoming entries (branch redirect)
- bubble_cnt  out  CNT_W  saturating count of decode-starved cycles

## Operation
- Storage: main entry (drives outputs) plus skid entry. Each entry has a valid bit and payload {next_pc, instr, next_instr}.
- Handshakes: accept = in_valid & in_ready; consume = out_valid & out_ready.
- in_ready = ~skid_valid & ~rst. This depends only on flops and rst, with no path from out_ready.
- out_valid = main_valid. out_* payload comes from the main entry. out_instr = NOP_INSTR when main_valid=0.
- States, derived from the valid bits:
  - EMPTY (main 0, skid 0)
  - ONE (main 1, skid 0)
  - FULL (main 1, skid 1)
- EMPTY:
  - accept -> ONE, main loads input.
- ONE:
  - accept & consume -> ONE, main loads input.
  - accept & ~consume -> FULL, skid loads input.
  - ~accept & consume -> EMPTY.
  - Otherwise hold.
- FULL (in_ready=0, so no accept):
  - consume -> ONE, main loads skid, skid cleared.
  - Otherwise hold.
- flush has priority over every transition except rst. Next state is EMPTY and any input accepted in the same cycle is discarded. Consume in the flush cycle still counts as a completed transfer downstream. in_ready during a flush cycle follows the normal rule.
- Payload registers of invalid entries are don't-care, except that out_instr must read NOP_INSTR.
- bubble_cnt:
  - Increments by 1 on each cycle with out_ready=1 & out_valid=0 & ~rst.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Unaffected by flush.
- rst (synchronous) clears both valid bits, all payload flops to 0, and bubble_cnt to 0. Any handshake in the reset cycle is ignored.

## Timing
- Reset values:
  - out_valid=0, out_instr=NOP_INSTR, out_next_instr=0, out_next_pc=0, bubble_cnt=0.
  - in_ready=0 while rst=1; in_ready=1 in the first cycle after rst deasserts.
- Latency: an instruction accepted at edge N is visible on out_* with out_valid=1 after edge N. This is one cycle, the same as the old IF/ID latch.
- Throughput: one instruction per cycle while out_ready=1, with no bubbles.
- Back-pressure: the first stall cycle absorbs one extra entry into skid. in_ready drops after that edge and rises one cycle after the consume that drains skid.
- Flush at edge N: out_valid=0 and in_ready=1 after N. An accept in cycle N+1 appears at N+2.
- Reset mid-operation: both entries are lost; behaviour is identical to power-up reset.
- Simultaneous events:
  - rst beats flush; flush beats accept and consume.
  - In FULL, accept cannot occur by construction.

## Test plan
- Reset then stream: rst 2 cycles; in_valid=1 with instr 0x11,0x22,0x33 (next_pc 1,2,3), out_ready=1.
  - Required: out_valid=0 and out_instr=NOP_INSTR during reset.
  - Required: outputs 0x11,0x22,0x33 on consecutive cycles, each one cycle after its accept.
- Stall fill: ONE holding 0x11, out_ready=0, offer 0x22.
  - Required: 0x22 accepted into skid, in_ready=0 next cycle, out_instr holds 0x11.
  - Required: after out_ready=1, the sequence is 0x11 then 0x22, with in_ready=1 the cycle after 0x11 is consumed.
- Flush in FULL: entries 0x11/0x22 held, flush=1.
  - Required: out_valid=0, out_instr=NOP_INSTR, in_ready=1 next cycle.
  - Required: a subsequent 0x44 arrives one cycle after its accept; 0x11 and 0x22 never appear.
- Flush with simultaneous accept: ONE holding 0x11, in_valid=1 with 0x55, flush=1.
  - Required: state EMPTY next cycle; 0x55 is never output.
- Bubble counter: CNT_W=2, out_ready=1, in_valid=0 for 5 cycles.
  - Required: bubble_cnt goes 1,2,3,3,3 and is unchanged by a flush pulse.
- Reset mid-stream: rst asserted while FULL.
  - Required: next cycle out_valid=0, bubble_cnt=0, payload outputs 0, in_ready=0 until rst deasserts.
